icache: RTL and testbench



---
 rtl/icache.sv | 107 ++++++++++
 tb/tb_icache.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with single-word miss fill.
// Hits return in the same cycle; misses fetch one word, then replay the lookup in IDLE.
module icache #(
  parameter int SETS  = 16,
  parameter int IDX_W = $clog2(SETS),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t            state, next_state;
  logic [SETS-1:0]   valid;
  logic [TAG_W-1:0]  tags [SETS];
  logic [31:0]       data [SETS];
  logic [29:0]       fill_word;

  logic [IDX_W-1:0]  idx, fill_idx;
  logic [TAG_W-1:0]  tag, fill_tag;
  logic              hit, miss, fill_done;
  logic              unused_bits;

  assign idx         = imemaddr[IDX_W+1:2];
  assign tag         = imemaddr[31:IDX_W+2];
  assign fill_idx    = fill_word[IDX_W-1:0];
  assign fill_tag    = fill_word[29:IDX_W];
  assign unused_bits = ^imemaddr[1:0];

  assign hit       = imemREN & valid[idx] & (tags[idx] == tag);
  assign miss      = (state == IDLE) & imemREN & ~hit;
  assign fill_done = (state == FETCH) & ~iwait;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (miss)  next_state = FETCH;
      FETCH:   if (!iwait) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ihit     = 1'b0;
    imemload = 32'h0;
    iREN     = 1'b0;
    iaddr    = 32'h0;
    case (state)
      IDLE: begin
        ihit     = hit;
        imemload = hit ? data[idx] : 32'h0;
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = {fill_word, 2'b00};
      end
      default: ;
    endcase
  end

  // Latched fill address lets the fetch stage move imemaddr during FETCH.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)       fill_word <= '0;
    else if (miss) fill_word <= imemaddr[31:2];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)            valid           <= '0;
    else if (fill_done) valid[fill_idx] <= 1'b1;
  end

  // Tag/data are qualified by valid, so they need no reset.
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tags[fill_idx] <= fill_tag;
      data[fill_idx] <= iload;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hit_count  <= 32'h0;
      miss_count <= 32'h0;
    end else if (state == IDLE && hit) begin
      hit_count  <= hit_count + 32'd1;
    end else if (miss) begin
      miss_count <= miss_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: scoreboard of expected instruction words popped on ihit,
// plus latency, fill-handshake and counter checks per scenario.
module tb_icache;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int vec  = 0;
  int errs = 0;
  int wcnt = 0;
  logic [31:0] exp_q[$];

  icache #(.SETS(16)) dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C220004;
    return 32'hC0DE0000 | {16'h0, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory model: wcnt wait cycles per fill, then returns mem_word(iaddr).
  initial begin
    forever begin
      @(negedge CLK);
      iload = mem_word(iaddr);
      iwait = (wcnt != 0);
      if (iREN && wcnt != 0) wcnt--;
    end
  end

  // Scoreboard monitor: every hit must deliver the next expected word.
  initial begin
    logic [31:0] exp;
    forever begin
      @(negedge CLK);
      if (!RST && ihit) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_hit", imemload, 32'hxxxxxxxx);
        end else begin
          exp = exp_q.pop_front();
          chk("imemload", imemload, exp);
        end
      end else if (!RST && imemREN) begin
        chk("imemload_idle_zero", imemload, 32'h0);
      end
    end
  end

  // Issue one request, hold it until ihit, then drop it.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] word,
                       input int w, input int exp_lat, input int exp_ren);
    int lat = 0, ren = 0;
    bit got = 0;
    @(posedge CLK); #1;
    wcnt = w;
    exp_q.push_back(word);
    imemaddr = addr;
    imemREN  = 1'b1;
    while (!got && lat < 50) begin
      @(negedge CLK);
      if (iREN) begin
        ren++;
        chk("iaddr", iaddr, {addr[31:2], 2'b00});
      end
      if (ihit) got = 1;
      else      lat++;
    end
    chk("hit_seen", 32'(got), 32'd1);
    chk("latency", lat, exp_lat);
    chk("iren_cycles", ren, exp_ren);
    @(posedge CLK); #1;
    imemREN = 1'b0;
  endtask

  initial begin
    int ren;
    RST = 1'b1; imemREN = 1'b0; imemaddr = 32'h0; iwait = 1'b0; iload = 32'h0;
    repeat (2) @(negedge CLK);
    chk("rst_ihit", 32'(ihit), 32'd0);
    chk("rst_imemload", imemload, 32'h0);
    chk("rst_iREN", 32'(iREN), 32'd0);
    chk("rst_iaddr", iaddr, 32'h0);
    chk("rst_hits", hit_count, 32'd0);
    chk("rst_misses", miss_count, 32'd0);
    #1 RST = 1'b0;

    // Cold miss, no wait, then same-address hit.
    fetch(32'h40, 32'h8C220004, 0, 2, 1);
    chk("cold_misses", miss_count, 32'd1);
    chk("cold_hits", hit_count, 32'd1);

    // Five wait states: FETCH held 6 cycles, hit at cycle 7.
    fetch(32'h100, 32'hC0DE0100, 5, 7, 6);
    chk("wait_misses", miss_count, 32'd2);

    // Index 0 conflict chain; the last fill must stay resident.
    fetch(32'h0,  32'hC0DE0000, 0, 2, 1);
    fetch(32'h40, 32'h8C220004, 0, 2, 1);
    fetch(32'h0,  32'hC0DE0000, 0, 2, 1);
    fetch(32'h0,  32'hC0DE0000, 0, 0, 0);
    chk("conflict_misses", miss_count, 32'd5);
    chk("conflict_hits", hit_count, 32'd6);

    // Request dropped after the miss: fill must still finish.
    @(posedge CLK); #1;
    wcnt = 3; imemaddr = 32'h20; imemREN = 1'b1;
    @(posedge CLK); #1;
    imemREN = 1'b0; imemaddr = 32'h44;
    ren = 0;
    repeat (8) begin
      @(negedge CLK);
      if (iREN) begin
        ren++;
        chk("drop_iaddr", iaddr, 32'h20);
      end
    end
    chk("drop_iren_cycles", ren, 4);
    fetch(32'h20, 32'hC0DE0020, 0, 0, 0);
    chk("drop_misses", miss_count, 32'd6);
    chk("drop_hits", hit_count, 32'd7);

    // Byte offset bits are ignored.
    fetch(32'h80, 32'hC0DE0080, 0, 2, 1);
    fetch(32'h83, 32'hC0DE0080, 0, 0, 0);
    chk("byte_hits", hit_count, 32'd9);

    // Reset mid-FETCH: iREN drops at once, valid and counters clear.
    @(posedge CLK); #1;
    wcnt = 10; imemaddr = 32'h200; imemREN = 1'b1;
    @(posedge CLK); #1;
    imemREN = 1'b0;
    @(negedge CLK);
    chk("pre_rst_iREN", 32'(iREN), 32'd1);
    #1 RST = 1'b1;
    #1;
    chk("rst_async_iREN", 32'(iREN), 32'd0);
    chk("rst_async_iaddr", iaddr, 32'h0);
    wcnt = 0; iwait = 1'b0;
    @(negedge CLK);
    chk("rst2_hits", hit_count, 32'd0);
    chk("rst2_misses", miss_count, 32'd0);
    #1 RST = 1'b0;
    fetch(32'h80, 32'hC0DE0080, 0, 2, 1);
    chk("post_rst_misses", miss_count, 32'd1);
    chk("post_rst_hits", hit_count, 32'd1);

    repeat (2) @(negedge CLK);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, expected to have finished", $time);
    $fatal(1);
  end

endmodule
